// File: rtl/hazard_scoreboard.sv
// Producer-side hazard control for the 5-stage rv32i pipeline: load-use stall/bubble, data-memory freeze, decode squash.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int PERF_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic [4:0]        dec_rd,
    input  logic              dec_uses_rs1,
    input  logic              dec_uses_rs2,
    input  logic              dec_load_regfile,
    input  logic              dec_is_load,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    input  logic              flush,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              freeze_all,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] bubble_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Stages a load result is still too young to be forwarded from: bit0=ex, bit1=mem, bit2=wb.
    localparam logic [2:0] LU_MASK = (LOAD_USE_BUBBLES >= 2) ? 3'b011 : 3'b001;

    state_t state_q, state_d;
    entry_t ex_q, mem_q, wb_q;
    entry_t ex_d, dec_e;
    logic   flush_pending_q, flush_pending_d;
    logic   eff_flush;
    logic   load_use;

    function automatic logic load_hit(
        input entry_t     e,
        input logic       en,
        input logic       u1,
        input logic [4:0] rs1,
        input logic       u2,
        input logic [4:0] rs2
    );
        load_hit = en && e.valid && e.wr && e.ld &&
                   ((u1 && (rs1 == e.rd)) || (u2 && (rs2 == e.rd)));
    endfunction

    always_comb begin
        state_d    = state_q;
        freeze_all = 1'b0;
        case (state_q)
            RUN: begin
                freeze_all = dmem_req && !dmem_resp;
                if (dmem_req && !dmem_resp) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                freeze_all = !dmem_resp;
                if (dmem_resp) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        eff_flush = (flush || flush_pending_q) && !freeze_all;
        load_use  = dec_valid &&
                    (load_hit(ex_q,  LU_MASK[0], dec_uses_rs1, dec_rs1, dec_uses_rs2, dec_rs2) ||
                     load_hit(mem_q, LU_MASK[1], dec_uses_rs1, dec_rs1, dec_uses_rs2, dec_rs2) ||
                     load_hit(wb_q,  LU_MASK[2], dec_uses_rs1, dec_rs1, dec_uses_rs2, dec_rs2));
        stall_if_id = !freeze_all && !eff_flush && load_use;
        bubble_ex   = !freeze_all && !eff_flush && load_use;

        // A flush seen while frozen is remembered until the pipeline can actually move.
        flush_pending_d = flush_pending_q;
        if (freeze_all) begin
            if (flush) flush_pending_d = 1'b1;
        end else begin
            flush_pending_d = 1'b0;
        end

        dec_e.valid = 1'b1;
        dec_e.rd    = dec_rd;
        dec_e.wr    = dec_load_regfile && (dec_rd != 5'd0);
        dec_e.ld    = dec_is_load;
        if (bubble_ex || eff_flush || !dec_valid) ex_d = '0;
        else                                      ex_d = dec_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            flush_pending_q <= 1'b0;
            ex_q            <= '0;
            mem_q           <= '0;
            wb_q            <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            if (!freeze_all) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] stall_cycles_q, bubble_count_q;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            bubble_count_q <= '0;
        end else begin
            if ((freeze_all || stall_if_id) && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + PERF_ONE;
            if (bubble_ex && (bubble_count_q != '1))
                bubble_count_q <= bubble_count_q + PERF_ONE;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
`endif

endmodule
